// File: rtl/udma_qspi_target_pkg.sv
// Shared command codes, FSM state encoding and command decoder for the QSPI target.
package udma_qspi_target_pkg;

  localparam logic [7:0] CMD_WR_S = 8'h02;
  localparam logic [7:0] CMD_WR_Q = 8'h32;
  localparam logic [7:0] CMD_RD_S = 8'h0B;
  localparam logic [7:0] CMD_RD_Q = 8'h6B;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_S,
    WR_Q,
    RD_S,
    RD_Q,
    IGNORE
  } target_state_e;

  // Unknown opcodes park the frame in IGNORE until CSN rises.
  function automatic target_state_e decode_cmd(input logic [7:0] opcode);
    case (opcode)
      CMD_WR_S: return WR_S;
      CMD_WR_Q: return WR_Q;
      CMD_RD_S: return RD_S;
      CMD_RD_Q: return RD_Q;
      default:  return IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/udma_qspi_target_sync.sv
// Pin synchroniser for the SPI host signals, with edge detection on SCLK and CSN.
module udma_qspi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       csn_in,
  input  logic [3:0] sdi_in,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       csn_level,
  output logic       csn_rise,
  output logic [3:0] sdi
);

  logic [SYNC_STAGES-1:0]      sclk_sync_reg;
  logic [SYNC_STAGES-1:0]      csn_sync_reg;
  logic [SYNC_STAGES-1:0][3:0] sdi_sync_reg;
  logic                        sclk_prev_reg;
  logic                        csn_prev_reg;

  // Idle levels (CSN high, SCLK low) so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      csn_sync_reg  <= '1;
      sdi_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      csn_prev_reg  <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk_in};
      csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], csn_in};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi_in};
      sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
      csn_prev_reg  <= csn_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[SYNC_STAGES-1] & sclk_prev_reg;
  assign csn_level = csn_sync_reg[SYNC_STAGES-1];
  assign csn_rise  = csn_sync_reg[SYNC_STAGES-1] & ~csn_prev_reg;
  assign sdi       = sdi_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/udma_qspi_target.sv
// QSPI target: decodes host opcodes, packs write data onto the RX stream and
// shifts TX stream words out on single or quad lanes.
module udma_qspi_target
  import udma_qspi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_csn_i,
  input  logic [3:0]            spi_sdi_i,
  output logic [3:0]            spi_sdo_o,
  output logic [3:0]            spi_oe_o,
  output logic [WORD_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [WORD_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  eot_o,
  output logic                  err_o
);

  localparam int               CNT_W    = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CMD = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_Q   = CNT_W'(WORD_WIDTH / 4 - 1);

  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  csn_level;
  logic                  csn_rise;
  logic [3:0]            sdi;

  target_state_e         state_reg;
  target_state_e         state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [6:0]            cmd_reg;
  logic [WORD_WIDTH-1:0] rx_shift_reg;
  logic [WORD_WIDTH-1:0] tx_shift_reg;
  logic [WORD_WIDTH-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  rx_pending_reg;
  logic                  skip_fall_reg;
  logic                  err_reg;
  logic                  eot_reg;

  logic                  cmd_done;
  logic                  word_done;
  logic                  tx_load;

  udma_qspi_target_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (sys_clk_i),
    .rst      (rst_i),
    .sclk_in  (spi_sclk_i),
    .csn_in   (spi_csn_i),
    .sdi_in   (spi_sdi_i),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .csn_level(csn_level),
    .csn_rise (csn_rise),
    .sdi      (sdi)
  );

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_done   = 1'b0;
    word_done  = 1'b0;
    tx_load    = 1'b0;
    if (csn_level) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = CMD;
        CMD: begin
          if (sclk_rise && cnt_reg == LAST_CMD) begin
            cmd_done   = 1'b1;
            state_next = decode_cmd({cmd_reg, sdi[0]});
            tx_load    = (state_next == RD_S) || (state_next == RD_Q);
          end
        end
        WR_S: word_done = sclk_rise && (cnt_reg == LAST_S);
        WR_Q: word_done = sclk_rise && (cnt_reg == LAST_Q);
        RD_S: tx_load = sclk_fall && !skip_fall_reg && (cnt_reg == LAST_S);
        RD_Q: tx_load = sclk_fall && !skip_fall_reg && (cnt_reg == LAST_Q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg        <= '0;
      cmd_reg        <= '0;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_pending_reg <= 1'b0;
      skip_fall_reg  <= 1'b0;
      err_reg        <= 1'b0;
      eot_reg        <= 1'b0;
    end else begin
      eot_reg        <= csn_rise;
      err_reg        <= 1'b0;
      rx_pending_reg <= word_done;

      if (rx_valid_reg && rx_ready_i) begin
        rx_valid_reg <= 1'b0;
      end
      // A word finishing as CSN rises is discarded with the rest of the frame.
      if (rx_pending_reg && !csn_level) begin
        if (rx_valid_reg && !rx_ready_i) begin
          err_reg <= 1'b1;
        end else begin
          rx_data_reg  <= rx_shift_reg;
          rx_valid_reg <= 1'b1;
        end
      end

      if (tx_load) begin
        tx_shift_reg <= tx_valid_i ? tx_data_i : '0;
        if (!tx_valid_i) begin
          err_reg <= 1'b1;
        end
      end

      if (csn_level || state_reg == IDLE) begin
        cnt_reg       <= '0;
        skip_fall_reg <= 1'b0;
      end else if (cmd_done) begin
        // The MSB is already on the pins; the fall closing the opcode must not shift it away.
        cnt_reg       <= '0;
        skip_fall_reg <= 1'b1;
      end else begin
        case (state_reg)
          CMD: begin
            if (sclk_rise) begin
              cmd_reg <= {cmd_reg[5:0], sdi[0]};
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          WR_S: begin
            if (sclk_rise) begin
              rx_shift_reg <= {rx_shift_reg[WORD_WIDTH-2:0], sdi[0]};
              cnt_reg      <= word_done ? '0 : cnt_reg + CNT_W'(1);
            end
          end
          WR_Q: begin
            if (sclk_rise) begin
              rx_shift_reg <= {rx_shift_reg[WORD_WIDTH-5:0], sdi};
              cnt_reg      <= word_done ? '0 : cnt_reg + CNT_W'(1);
            end
          end
          RD_S, RD_Q: begin
            if (sclk_fall) begin
              if (skip_fall_reg) begin
                skip_fall_reg <= 1'b0;
              end else if (tx_load) begin
                cnt_reg <= '0;
              end else begin
                tx_shift_reg <= (state_reg == RD_S) ? {tx_shift_reg[WORD_WIDTH-2:0], 1'b0}
                                                    : {tx_shift_reg[WORD_WIDTH-5:0], 4'h0};
                cnt_reg      <= cnt_reg + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    spi_sdo_o = 4'h0;
    spi_oe_o  = 4'h0;
    case (state_reg)
      RD_S: begin
        spi_oe_o  = 4'b0010;
        spi_sdo_o = {2'b00, tx_shift_reg[WORD_WIDTH-1], 1'b0};
      end
      RD_Q: begin
        spi_oe_o  = 4'b1111;
        spi_sdo_o = tx_shift_reg[WORD_WIDTH-1 -: 4];
      end
      default: ;
    endcase
  end

  assign tx_ready_o = tx_load & tx_valid_i;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;
  assign busy_o     = ~csn_level;
  assign eot_o      = eot_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_udma_qspi_target.sv
// Directed bench for udma_qspi_target: a behavioural SPI host drives frames at sys_clk/8.
module tb_udma_qspi_target;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        csn;
  logic [3:0]  sdi;
  logic [3:0]  sdo;
  logic [3:0]  oe;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        eot;
  logic        err;

  int checks = 0;
  int errors = 0;

  int          eot_cnt  = 0;
  int          err_cnt  = 0;
  int          txr_cnt  = 0;
  int          beat_cnt = 0;
  logic [31:0] beat_data = '0;

  logic [3:0]  rd_nib;
  logic [3:0]  seen_oe;

  udma_qspi_target #(
    .SYNC_STAGES(2),
    .WORD_WIDTH (32)
  ) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .spi_sclk_i(sclk),
    .spi_csn_i (csn),
    .spi_sdi_i (sdi),
    .spi_sdo_o (sdo),
    .spi_oe_o  (oe),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .busy_o    (busy),
    .eot_o     (eot),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and beat counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (eot) eot_cnt++;
    if (err) err_cnt++;
    if (tx_ready) txr_cnt++;
    if (rx_valid && rx_ready) begin
      beat_cnt++;
      beat_data = rx_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One host SCLK period: data set while low, sampled just before the rise.
  task automatic sclk_cycle(input logic [3:0] d);
    sdi = d;
    tick(4);
    rd_nib  = sdo;
    seen_oe = seen_oe | oe;
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic send_bits_s(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b000, v[i]});
  endtask

  task automatic send_nibbles(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle(v[4*i +: 4]);
  endtask

  task automatic read_s(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      sclk_cycle(4'h0);
      v = {v[30:0], rd_nib[1]};
    end
  endtask

  task automatic read_q(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      sclk_cycle(4'h0);
      v = {v[27:0], rd_nib};
    end
  endtask

  task automatic frame_start;
    csn = 1'b0;
    tick(4);
  endtask

  task automatic frame_end;
    tick(4);
    csn = 1'b1;
    sdi = 4'h0;
    tick(8);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, e0, r0, t0;
    logic [31:0] v;

    rst = 1'b1; sclk = 1'b0; csn = 1'b1; sdi = 4'h0;
    rx_ready = 1'b1; tx_data = '0; tx_valid = 1'b0; seen_oe = '0; rd_nib = '0;
    tick(3);
    rst = 1'b0;
    tick(3);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_oe", oe, 0);
    check_eq("rst_sdo", sdo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", eot_cnt + err_cnt + txr_cnt, 0);

    // 1: single write
    b0 = beat_cnt; e0 = eot_cnt; r0 = err_cnt;
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'hDEADBEEF, 32);
    check_eq("wr_s_busy", busy, 1);
    frame_end;
    check_eq("wr_s_beats", beat_cnt - b0, 1);
    check_eq("wr_s_data", beat_data, 32'hDEADBEEF);
    check_eq("wr_s_err", err_cnt - r0, 0);
    check_eq("wr_s_eot", eot_cnt - e0, 1);
    check_eq("wr_s_busy_end", busy, 0);
    $display("txn write_s rx=%h", beat_data);

    // 2: quad write
    b0 = beat_cnt; seen_oe = '0;
    frame_start;
    send_bits_s(32'h32, 8);
    send_nibbles(32'h12345678, 8);
    frame_end;
    check_eq("wr_q_beats", beat_cnt - b0, 1);
    check_eq("wr_q_data", beat_data, 32'h12345678);
    check_eq("wr_q_oe", seen_oe, 0);
    $display("txn write_q rx=%h", beat_data);

    // 3: single read
    tx_data = 32'hA5A50F0F; tx_valid = 1'b1;
    t0 = txr_cnt; r0 = err_cnt; seen_oe = '0;
    frame_start;
    send_bits_s(32'h0B, 8);
    check_eq("rd_s_cmd_oe", seen_oe, 0);
    check_eq("rd_s_txr_cmd", txr_cnt - t0, 1);
    seen_oe = '0;
    read_s(32, v);
    check_eq("rd_s_data", v, 32'hA5A50F0F);
    check_eq("rd_s_oe", seen_oe, 4'b0010);
    frame_end;
    check_eq("rd_s_txr_end", txr_cnt - t0, 2);
    check_eq("rd_s_err", err_cnt - r0, 0);
    check_eq("rd_s_oe_end", oe, 0);
    $display("txn read_s tx=%h", v);

    // 4: quad read underrun
    tx_valid = 1'b0;
    t0 = txr_cnt; r0 = err_cnt; e0 = eot_cnt; seen_oe = '0;
    frame_start;
    send_bits_s(32'h6B, 8);
    check_eq("rd_q_err_cmd", err_cnt - r0, 1);
    seen_oe = '0;
    read_q(8, v);
    check_eq("rd_q_data", v, 0);
    check_eq("rd_q_oe", seen_oe, 4'hF);
    frame_end;
    check_eq("rd_q_err_end", err_cnt - r0, 2);
    check_eq("rd_q_txr", txr_cnt - t0, 0);
    check_eq("rd_q_eot", eot_cnt - e0, 1);
    $display("txn read_q underrun data=%h", v);

    // 5: overflow
    rx_ready = 1'b0;
    b0 = beat_cnt; r0 = err_cnt;
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'h11111111, 32);
    send_bits_s(32'h22222222, 32);
    frame_end;
    check_eq("ovf_valid", rx_valid, 1);
    check_eq("ovf_held", rx_data, 32'h11111111);
    check_eq("ovf_err", err_cnt - r0, 1);
    check_eq("ovf_beats_held", beat_cnt - b0, 0);
    rx_ready = 1'b1;
    tick(4);
    check_eq("ovf_beat_data", beat_data, 32'h11111111);
    tick(20);
    check_eq("ovf_beats", beat_cnt - b0, 1);
    check_eq("ovf_valid_end", rx_valid, 0);
    $display("txn overflow rx=%h", beat_data);

    // 6a: abort after 12 data bits, then a clean frame
    b0 = beat_cnt; e0 = eot_cnt;
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'hABC, 12);
    frame_end;
    check_eq("abort_beats", beat_cnt - b0, 0);
    check_eq("abort_eot", eot_cnt - e0, 1);
    check_eq("abort_busy", busy, 0);
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'hCAFEF00D, 32);
    frame_end;
    check_eq("post_abort_data", beat_data, 32'hCAFEF00D);
    check_eq("post_abort_beats", beat_cnt - b0, 1);
    $display("txn abort then write rx=%h", beat_data);

    // 6b: async reset in the middle of a quad read
    rx_ready = 1'b0;
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'h5A5A5A5A, 32);
    frame_end;
    check_eq("pre_rst_valid", rx_valid, 1);
    tx_data = 32'h13579BDF; tx_valid = 1'b1;
    frame_start;
    send_bits_s(32'h6B, 8);
    read_q(3, v);
    check_eq("pre_rst_rd_q", v, 32'h135);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_oe", oe, 0);
    check_eq("arst_sdo", sdo, 0);
    check_eq("arst_rx_valid", rx_valid, 0);
    csn = 1'b1; sclk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    rx_ready = 1'b1;
    b0 = beat_cnt;
    frame_start;
    send_bits_s(32'h02, 8);
    send_bits_s(32'h0BADF00D, 32);
    frame_end;
    check_eq("post_rst_beats", beat_cnt - b0, 1);
    check_eq("post_rst_data", beat_data, 32'h0BADF00D);
    $display("txn reset then write rx=%h", beat_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
